gray_counter_n: RTL



---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_to_bin.sv | 17 +
 rtl/gray_counter_n.sv | 95 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the Gray counter family.
package gray_pkg;

    localparam int GRAY_WIDTH_MIN = 2;
    localparam int GRAY_WIDTH_MAX = 16;

    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
        input logic [GRAY_WIDTH_MAX-1:0] b,
        input int unsigned               w
    );
        logic [GRAY_WIDTH_MAX-1:0] mask;
        mask = {GRAY_WIDTH_MAX{1'b1}} >> (GRAY_WIDTH_MAX - int'(w));
        return (b ^ (b >> 1)) & mask;
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result unaffected.
    function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(
        input logic [GRAY_WIDTH_MAX-1:0] g,
        input int unsigned               w
    );
        logic [GRAY_WIDTH_MAX-1:0] b;
        logic [GRAY_WIDTH_MAX-1:0] mask;
        b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        mask = {GRAY_WIDTH_MAX{1'b1}} >> (GRAY_WIDTH_MAX - int'(w));
        return b & mask;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter (XOR prefix), also reused by FIFO pointer synchronisers.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised Gray counter with load, wrap pulse and overflow flag.
// Down counting and the Dir port are built only when GRAY_CNT_DIR_EN is defined.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter bit STICKY = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
`ifdef GRAY_CNT_DIR_EN
    input  logic             Dir,
`endif
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrOvf,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Wrap,
    output logic             Overflow
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic             w_wrap_evt;

    gray_to_bin #(.WIDTH(WIDTH)) u_load_conv (
        .i_gray (LoadVal),
        .o_bin  (w_load_bin)
    );

`ifdef GRAY_CNT_DIR_EN
    always_comb begin
        w_bin_next = r_bin;
        w_wrap_evt = 1'b0;
        if (Load) begin
            w_bin_next = w_load_bin;
        end else if (En) begin
            if (Dir) begin
                w_bin_next = r_bin - WIDTH'(1);
                w_wrap_evt = (r_bin == '0);
            end else begin
                w_bin_next = r_bin + WIDTH'(1);
                w_wrap_evt = &r_bin;
            end
        end
    end
`else
    always_comb begin
        w_bin_next = r_bin;
        w_wrap_evt = 1'b0;
        if (Load) begin
            w_bin_next = w_load_bin;
        end else if (En) begin
            w_bin_next = r_bin + WIDTH'(1);
            w_wrap_evt = &r_bin;
        end
    end
`endif

    // Gray and binary registers load from the same next-state value, so Output never glitches.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= WIDTH'(bin2gray(GRAY_WIDTH_MAX'(w_bin_next), WIDTH));
            r_wrap <= w_wrap_evt;
            if (STICKY) begin
                if (w_wrap_evt) begin
                    r_ovf <= 1'b1;
                end else if (ClrOvf) begin
                    r_ovf <= 1'b0;
                end
            end else begin
                r_ovf <= w_wrap_evt;
            end
        end
    end

    assign Output   = r_gray;
    assign Binary   = r_bin;
    assign Wrap     = r_wrap;
    assign Overflow = r_ovf;

endmodule
